// File: rtl/seg_disp_sched_pkg.sv
// seg_disp_sched shared types: FSM state, widths, double-dabble step.
// Imported by the request interface, the bin2bcd_seq engine and the top.
package seg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_HOLD
  } state_t;

  localparam int VAL_W = 10;
  localparam int DIG_W = 4;
  localparam int BCD_W = 16;
  localparam int SH_W  = BCD_W + VAL_W;

  // digits at or above this value get +3 before the shift
  localparam logic [DIG_W-1:0] ADD3_TH = 4'd5;

  function automatic logic [SH_W-1:0] dabble_step(
    input logic [SH_W-1:0] s
  );
    logic [SH_W-1:0] t;
    t = s;
    for (int d = 0; d < BCD_W / DIG_W; d++) begin
      if (t[VAL_W+DIG_W*d +: DIG_W] >= ADD3_TH)
        t[VAL_W+DIG_W*d +: DIG_W] =
          t[VAL_W+DIG_W*d +: DIG_W] + 4'd3;
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg_disp_sched_if.sv
// Request handshake bundle: per-source valid/value in, one-hot ready out.
// master = requesters, slave = scheduler.
interface seg_disp_sched_if #(
  parameter int NUM_SRC = 3
);

  logic [NUM_SRC-1:0]              req_valid_i;
  logic [NUM_SRC*seg_pkg::VAL_W-1:0] req_value_i;
  logic [NUM_SRC-1:0]              req_ready_o;

  modport master (
    output req_valid_i,
    output req_value_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_value_i,
    output req_ready_o
  );

endinterface

// File: rtl/seg_disp_sched_bin2bcd_seq.sv
// Sequential double-dabble: bin_i loaded on start, 10 iterations, done
// high for one cycle with bcd_o final. Ports: clk, rst_n, start, bin_i, busy, done, bcd_o.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] bin_i,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_o
);

  logic [SH_W-1:0] sh_q;
  logic [3:0]      cnt_q;
  logic            busy_q;

  // first iteration is folded into the load edge, so the result
  // sits in sh_q during the tenth busy cycle
  assign done  = busy_q && (cnt_q == 4'(VAL_W));
  assign busy  = busy_q;
  assign bcd_o = sh_q[SH_W-1:VAL_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      sh_q   <= dabble_step({{BCD_W{1'b0}}, bin_i});
      cnt_q  <= 4'd1;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (done) begin
        busy_q <= 1'b0;
      end else begin
        sh_q  <= dabble_step(sh_q);
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Display scheduler: round-robin grant, BCD conversion, dwell, scan strobe.
// Ports: clk, rst_n, req (slave), bcd_o, src_o, blank_o, scan_tick_o, busy_o.
module seg_disp_sched
  import seg_pkg::*;
#(
  parameter int NUM_SRC  = 3,
  parameter int HOLD_CYC = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_disp_sched_if.slave  req,
  output logic [BCD_W-1:0] bcd_o,
  output logic [1:0]       src_o,
  output logic             blank_o,
  output logic             scan_tick_o,
  output logic             busy_o
);

  localparam int HW = $clog2(HOLD_CYC) + 1;
  localparam int SW = $clog2(SCAN_DIV);

  state_t           state_q;
  logic [1:0]       last_q;
  logic [HW-1:0]    dwell_q;
  logic [BCD_W-1:0] bcd_q;
  logic [1:0]       src_q;
  logic             blank_q;
  logic [SW-1:0]    scan_q;
  logic [SW-1:0]    scan_d;

  logic [NUM_SRC-1:0] valid;
  logic [1:0]         pick;
  logic               grant;
  logic [VAL_W-1:0]   pick_val;
  logic               cv_busy;
  logic               cv_done;
  logic [BCD_W-1:0]   cv_bcd;

  // nearest valid source after last, wrapping; descending loop
  // so the smallest offset is assigned last and wins
  function automatic logic [1:0] rr_pick(
    input logic [NUM_SRC-1:0] v,
    input logic [1:0]         last
  );
    logic [1:0] idx;
    int         k;
    idx = last;
    for (int i = NUM_SRC; i >= 1; i--) begin
      k = (int'(last) + i) % NUM_SRC;
      if (v[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  assign valid    = req.req_valid_i;
  assign pick     = rr_pick(valid, last_q);
  assign grant    = rst_n && (state_q == S_IDLE) && (|valid);
  assign pick_val = req.req_value_i[int'(pick)*VAL_W +: VAL_W];

  always_comb begin
    req.req_ready_o = '0;
    for (int i = 0; i < NUM_SRC; i++)
      req.req_ready_o[i] = grant && (pick == 2'(i));
  end

  bin2bcd_seq u_b2b (
    .clk   (clk),
    .rst_n (rst_n),
    .start (grant),
    .bin_i (pick_val),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd_o (cv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 2'(NUM_SRC - 1);
      dwell_q <= '0;
      bcd_q   <= '0;
      src_q   <= '0;
      blank_q <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (grant) begin
            last_q  <= pick;
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (cv_done) begin
            bcd_q   <= cv_bcd;
            src_q   <= last_q;
            blank_q <= 1'b0;
            dwell_q <= '0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (dwell_q == HW'(HOLD_CYC - 1)) begin
            dwell_q <= '0;
            state_q <= S_IDLE;
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // free-running, unaffected by the FSM
  assign scan_tick_o = (scan_q == SW'(SCAN_DIV - 1));
  assign scan_d      = scan_tick_o ? '0 : scan_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_q <= '0;
    else        scan_q <= scan_d;
  end

  assign bcd_o   = bcd_q;
  assign src_o   = src_q;
  assign blank_o = blank_q;
  // engine busy covers CONVERT exactly
  assign busy_o  = cv_busy || (state_q == S_HOLD);

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed bench for seg_disp_sched with an expected-display scoreboard.
// NUM_SRC=3, HOLD_CYC=4, SCAN_DIV=4.
module tb_seg_disp_sched;

  localparam int NS = 3;
  localparam int HC = 4;
  localparam int SD = 4;

  typedef struct {
    int          src;
    logic [15:0] bcd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_o;
  logic [1:0]  src_o;
  logic        blank_o;
  logic        scan_tick_o;
  logic        busy_o;

  seg_disp_sched_if #(.NUM_SRC(NS)) bus ();

  seg_disp_sched #(
    .NUM_SRC  (NS),
    .HOLD_CYC (HC),
    .SCAN_DIV (SD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (bus),
    .bcd_o       (bcd_o),
    .src_o       (src_o),
    .blank_o     (blank_o),
    .scan_tick_o (scan_tick_o),
    .busy_o      (busy_o)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   g_cyc = 0;
  int   prev_g;
  int   msc;
  exp_t sb[$];
  logic [15:0] shown_bcd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // independent scan model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) msc <= 0;
    else        msc <= (msc == SD - 1) ? 0 : msc + 1;
  end

  always @(negedge clk) chk("scan_tick", 32'(scan_tick_o), 32'(msc == SD - 1));

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int s, input int v);
    bus.req_valid_i[s] = 1'b1;
    bus.req_value_i[s*10 +: 10] = 10'(v);
    sb.push_back('{s, to_bcd(v)});
  endtask

  // waits for a grant, then follows it to the display update at G+11
  task automatic do_grant(input int exp_src, input bit drop);
    exp_t e;
    bit   hit;
    hit = 1'b0;
    #1;
    for (int k = 0; k < 200; k++) begin
      if (bus.req_ready_o != '0) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    if (!hit) begin
      total++;
      bad++;
      $error("FAIL grant_timeout obs=none exp=src%0d", exp_src);
      return;
    end
    g_cyc = cyc;
    chk("ready_onehot", 32'(bus.req_ready_o), 32'(1) << exp_src);
    chk("busy_at_G", 32'(busy_o), 32'd0);
    step();
    if (drop) bus.req_valid_i[exp_src] = 1'b0;
    chk("ready_G1", 32'(bus.req_ready_o), 32'd0);
    chk("busy_G1", 32'(busy_o), 32'd1);
    repeat (9) step();
    chk("bcd_held_G10", 32'(bcd_o), 32'(shown_bcd));
    step();
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty obs=empty exp=entry");
      return;
    end
    e = sb.pop_front();
    chk("bcd_G11", 32'(bcd_o), 32'(e.bcd));
    chk("src_G11", 32'(src_o), 32'(e.src));
    chk("blank_G11", 32'(blank_o), 32'd0);
    chk("busy_G11", 32'(busy_o), 32'd1);
    for (int d = 0; d < 4; d++)
      chk("digit_le9", 32'(bcd_o[4*d +: 4] <= 4'd9), 32'd1);
    shown_bcd = e.bcd;
  endtask

  task automatic chk_reset_vals();
    chk("rst_bcd", 32'(bcd_o), 32'd0);
    chk("rst_src", 32'(src_o), 32'd0);
    chk("rst_blank", 32'(blank_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_tick", 32'(scan_tick_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    chk_reset_vals();
    step();
    rst_n = 1'b1;
    shown_bcd = 16'h0;
  endtask

  initial begin
    int bv[8];
    bv = '{0, 9, 10, 99, 100, 999, 1000, 1023};
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    bus.req_value_i = '0;
    shown_bcd = 16'h0;
    step();
    do_reset();

    // single request
    step();
    chk("blank_idle", 32'(blank_o), 32'd1);
    drive(0, 357);
    do_grant(0, 1'b1);

    // all three held valid from reset
    do_reset();
    drive(0, 5);
    drive(1, 42);
    drive(2, 1023);
    sb.push_back('{0, to_bcd(5)});
    do_grant(0, 1'b0);
    prev_g = g_cyc;
    for (int s = 1; s <= 3; s++) begin
      do_grant(s % 3, 1'b0);
      chk("grant_spacing", 32'(g_cyc - prev_g), 32'd15);
      prev_g = g_cyc;
    end
    bus.req_valid_i = '0;
    repeat (6) step();

    // boundary values
    foreach (bv[i]) begin
      drive(0, bv[i]);
      do_grant(0, 1'b1);
    end

    // request arriving during HOLD
    repeat (6) step();
    drive(0, 77);
    do_grant(0, 1'b0);
    prev_g = g_cyc;
    drive(1, 500);
    for (int k = 0; k < HC; k++) begin
      chk("no_ready_hold", 32'(bus.req_ready_o), 32'd0);
      step();
    end
    do_grant(1, 1'b1);
    bus.req_valid_i[0] = 1'b0;
    chk("hold_grant_cyc", 32'(g_cyc - prev_g), 32'd15);
    repeat (6) step();

    // reset mid-CONVERT with the request still held
    drive(2, 640);
    void'(sb.pop_back());
    #1;
    for (int k = 0; k < 50 && bus.req_ready_o == '0; k++) step();
    chk("pre_rst_grant", 32'(bus.req_ready_o), 32'b100);
    repeat (4) step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    step();
    chk_reset_vals();
    rst_n = 1'b1;
    shown_bcd = 16'h0;
    sb.push_back('{2, to_bcd(640)});
    do_grant(2, 1'b1);
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_disp_sched.md
# seg_disp_sched

Display scheduler in front of the 4-digit seven-segment scanner. Arbitrates round-robin among NUM_SRC requesters that want a 10-bit binary value shown, converts the granted value to four BCD digits with a sequential double-dabble engine, and holds it for a fixed dwell time. It also generates the digit-scan strobe that paces the scanner.

## Interface
- NUM_SRC, 3: number of requesters, 2..4.
- HOLD_CYC, 50_000_000: dwell cycles per displayed value, ≥1.
- SCAN_DIV, 50_000: scan-strobe period in cycles, ≥2.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_SRC  per-source display request; held until granted.
- req_value_i  in  NUM_SRC*10  packed binary values; source i in bits [10i+9:10i]; range 0..1023.
- req_ready_o  out  NUM_SRC  one-hot grant; transfer when valid&ready.
- bcd_o  out  16  {thousands, hundreds, tens, ones}, 4 bits each.
- src_o  out  2  index of the source currently shown.
- blank_o  out  1  high until the first value is displayed.
- scan_tick_o  out  1  one-cycle strobe every SCAN_DIV cycles.
- busy_o  out  1  high in CONVERT and HOLD.

## Operation
- FSM states: IDLE, CONVERT, HOLD.
- IDLE:
  - req_ready_o is combinational: one-hot of the first valid source, searching from (last_grant+1) mod NUM_SRC upward with wrap.
  - If any source is valid: latch its value, update last_grant, go to CONVERT.
  - If none is valid: stay in IDLE.
- CONVERT: bin2bcd_seq runs 10 shift/add-3 iterations, one per cycle. On done, bcd_o, src_o ← grant index, and blank_o ← 0 are registered together; go to HOLD.
- HOLD: dwell counter runs 0..HOLD_CYC-1. At the terminal count, go to IDLE.
- No request in IDLE: the last value stays on bcd_o/src_o. blank_o never reasserts except on reset.
- Requests are ignored outside IDLE. A source may drop valid before being granted with no side effect.
- Only the value present on the grant cycle is used.
- Arithmetic: values 0..1023 always fit in 4 BCD digits, so no saturation. Each digit is ≤9 after conversion.
- Scan prescaler: free-running from reset, independent of the FSM. scan_tick_o is high when count = SCAN_DIV-1, then the count wraps to 0.
- Reset (asynchronous, any state, including mid-conversion): immediately forces
  - state IDLE, last_grant NUM_SRC-1 (source 0 wins first), dwell and scan counters 0;
  - bcd_o 0, src_o 0, blank_o 1, busy_o 0, scan_tick_o 0, req_ready_o 0.

## Timing
- Grant cycle G: IDLE with at least one valid source; req_ready_o high for exactly one cycle.
- CONVERT occupies cycles G+1..G+10; bin2bcd_seq done is high in G+10.
- bcd_o, src_o and blank_o update on the edge ending G+10, so they are visible from G+11.
- HOLD occupies cycles G+11..G+10+HOLD_CYC. IDLE resumes at G+11+HOLD_CYC.
- Minimum grant-to-grant spacing is therefore 11+HOLD_CYC cycles.
- busy_o is high from G+1 through G+10+HOLD_CYC.
- First scan_tick_o is at cycle SCAN_DIV-1 after reset release, then every SCAN_DIV cycles.

## Structure
- Package seg_pkg holds:
  - state enum;
  - VAL_W=10, DIG_W=4, BCD_W=16;
  - the add-3 threshold constant.
- Sub-module bin2bcd_seq:
  - ports: clk, rst_n, start, bin_i[9:0], busy, done, bcd_o[15:0];
  - loads bin_i on start; done pulses after 10 iterations.
- The round-robin pick is a function in seg_disp_sched.

## Test plan
- Reset, then source 0 valid with 357 at G:
  - req_ready_o=001 at G;
  - bcd_o=0x0357, src_o=0, blank_o 1→0 at G+11.
- Sources 0, 1, 2 all held valid with 5, 42 and 1023; HOLD_CYC=4:
  - grants occur in order 0, 1, 2, 0, spaced 15 cycles apart;
  - bcd_o shows 0x0005, 0x0042, 0x1023.
- Boundary values 0, 9, 10, 99, 100, 999, 1000 and 1023 → corresponding BCD; every digit ≤9.
- Source 1 valid during HOLD of source 0:
  - no req_ready_o until the first IDLE cycle;
  - source 1 is granted then, even if source 0 is also valid.
- Assert rst_n low at G+5, mid-CONVERT:
  - all outputs return to reset values within the same cycle;
  - after release, a new request converts correctly.
- SCAN_DIV=4: scan_tick_o high at cycles 3, 7, 11, … regardless of FSM activity.
